// File: rtl/tt_pkg.sv
// Shared types and size derivations for the truth-table LUT evaluator.
package tt_pkg;

  // Serial-config FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } cfg_state_e;

  // Number of entries in one channel's truth table.
  function automatic int unsigned tt_depth(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // Total number of serial config bits across all channels.
  function automatic int unsigned cfg_bits(input int unsigned n_in, input int unsigned n_ch);
    return n_ch * tt_depth(n_in);
  endfunction

endpackage

// File: rtl/tt_cfg_loader.sv
// Serial truth-table loader: shifts config bits into a shadow register and
// raises a one-cycle commit pulse once every bit has arrived.
module tt_cfg_loader
  import tt_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned N_CH = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_bit_valid,
  input  logic                             cfg_bit,
  output logic [cfg_bits(N_IN, N_CH)-1:0] shadow_o,
  output logic                             commit_o,
  output logic                             busy_o
);

  localparam int unsigned CfgBits = cfg_bits(N_IN, N_CH);
  localparam int unsigned KW      = $clog2(CfgBits);

  cfg_state_e         state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CfgBits-1:0] shadow_q, shadow_d;

  // Next-state, bit counter and shadow write.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StShift;
          k_d     = '0;
        end
      end
      StShift: begin
        if (cfg_start) begin
          // Restart: a bit arriving with the restart lands at position 0.
          if (cfg_bit_valid) begin
            shadow_d[0] = cfg_bit;
            k_d         = KW'(1);
          end else begin
            k_d = '0;
          end
        end else if (cfg_bit_valid) begin
          shadow_d[k_q] = cfg_bit;
          if (k_q == KW'(CfgBits - 1)) begin
            state_d = StCommit;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;
  assign commit_o = (state_q == StCommit);
  assign busy_o   = (state_q == StShift) || (state_q == StCommit);

endmodule

// File: rtl/tt_lut_eval.sv
// Multi-channel truth-table evaluator with a serially reloadable table set
// and a single-stage valid/ready output register.
module tt_lut_eval
  import tt_pkg::*;
#(
  parameter int unsigned               N_IN    = 4,
  parameter int unsigned               N_CH    = 1,
  parameter logic [tt_depth(N_IN)-1:0] TT_INIT = (tt_depth(N_IN))'(16'hBC16)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_bit_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_CH-1:0] out_y
);

  localparam int unsigned TtDepth = tt_depth(N_IN);
  localparam int unsigned CfgBits = cfg_bits(N_IN, N_CH);

  logic [CfgBits-1:0] shadow;
  logic               commit;

  tt_cfg_loader #(
    .N_IN(N_IN),
    .N_CH(N_CH)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit      (cfg_bit),
    .shadow_o     (shadow),
    .commit_o     (commit),
    .busy_o       (cfg_busy)
  );

  // Shadow bit k maps to channel k/TtDepth, entry k%TtDepth: same packing.
  logic [N_CH-1:0][TtDepth-1:0] active_q, active_d;
  logic                         out_valid_q, out_valid_d;
  logic [N_CH-1:0]              out_y_q, out_y_d;
  logic                         accept;

  assign in_ready = (!out_valid_q || out_ready) && !commit;
  assign accept   = in_valid && in_ready;
  assign cfg_done = commit;

  // Whole-table swap on commit; lookup and output-register next state.
  always_comb begin
    active_d    = active_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (commit) begin
      active_d = shadow;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      for (int c = 0; c < int'(N_CH); c++) begin
        out_y_d[c] = active_q[c][in_x];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Active tables and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= {N_CH{TT_INIT}};
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_tt_lut_eval.sv
// Directed bench for tt_lut_eval: default 4-input/1-channel instance plus a
// 3-input/2-channel instance.
module tb_tt_lut_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance.
  logic       rst, cfg_start, cfg_bit_valid, cfg_bit, cfg_busy, cfg_done;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_x;
  logic [0:0] out_y;

  // Multi-channel instance.
  logic       m_rst, m_cfg_start, m_cfg_bit_valid, m_cfg_bit, m_cfg_busy, m_cfg_done;
  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [2:0] m_in_x;
  logic [1:0] m_out_y;

  int n_checks = 0;
  int n_err    = 0;

  tt_lut_eval dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_bit_valid(cfg_bit_valid),
    .cfg_bit      (cfg_bit),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y)
  );

  tt_lut_eval #(
    .N_IN   (3),
    .N_CH   (2),
    .TT_INIT(8'hA5)
  ) m_dut (
    .clk          (clk),
    .rst          (m_rst),
    .cfg_start    (m_cfg_start),
    .cfg_bit_valid(m_cfg_bit_valid),
    .cfg_bit      (m_cfg_bit),
    .cfg_busy     (m_cfg_busy),
    .cfg_done     (m_cfg_done),
    .in_valid     (m_in_valid),
    .in_ready     (m_in_ready),
    .in_x         (m_in_x),
    .out_valid    (m_out_valid),
    .out_ready    (m_out_ready),
    .out_y        (m_out_y)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift bits lo..hi of data; cfg_done must stay low except after the last bit.
  task automatic send_bits(input logic [15:0] data, input int lo, input int hi,
                           input logic done_at_end);
    for (int i = lo; i <= hi; i++) begin
      cfg_bit_valid = 1'b1;
      cfg_bit       = data[i];
      tick();
      chk($sformatf("cfg_done bit %0d", i), 32'(cfg_done),
          (i == hi) ? 32'(done_at_end) : 32'd0);
    end
    cfg_bit_valid = 1'b0;
    cfg_bit       = 1'b0;
  endtask

  // Evaluate one vector on the default instance (out_ready assumed high).
  task automatic eval(input logic [3:0] x, input logic exp, input string tag);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    chk(tag, {31'd0, out_y}, 32'(exp));
    in_valid = 1'b0;
  endtask

  task automatic m_eval(input logic [2:0] x, input logic [1:0] exp, input string tag);
    m_in_valid = 1'b1;
    m_in_x     = x;
    tick();
    chk(tag, {30'd0, m_out_y}, 32'(exp));
    m_in_valid = 1'b0;
  endtask

  logic sweep_exp [16] = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1};
  logic [15:0] d8000 = 16'h8000;
  logic [15:0] d0001 = 16'h0001;
  logic [15:0] dffff = 16'hFFFF;
  logic [15:0] d0ff0 = 16'h0FF0;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    m_rst = 1'b1; m_cfg_start = 1'b0; m_cfg_bit_valid = 1'b0; m_cfg_bit = 1'b0;
    m_in_valid = 1'b0; m_in_x = '0; m_out_ready = 1'b1;
    tick();
    tick();

    // Reset state.
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_y", {31'd0, out_y}, 32'd0);
    chk("rst cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst cfg_done", 32'(cfg_done), 32'd0);
    rst   = 1'b0;
    m_rst = 1'b0;
    tick();
    chk("in_ready after rst", 32'(in_ready), 32'd1);

    // Reset table sweep, back to back.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_x = 4'(i);
      tick();
      chk($sformatf("sweep x=%0d", i), {31'd0, out_y}, 32'(sweep_exp[i]));
      chk($sformatf("sweep valid x=%0d", i), 32'(out_valid), 32'd1);
    end

    // Backpressure: result for x=1 holds while out_ready is low.
    in_x = 4'd1;
    tick();
    chk("bp first", {31'd0, out_y}, 32'd1);
    out_ready = 1'b0;
    in_x      = 4'd3;
    #1;
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp hold y", {31'd0, out_y}, 32'd1);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp next y", {31'd0, out_y}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("valid clears", 32'(out_valid), 32'd0);

    // Reload with 16'h8000.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy in shift", 32'(cfg_busy), 32'd1);
    send_bits(d8000, 0, 15, 1'b1);
    chk("busy in commit", 32'(cfg_busy), 32'd1);
    chk("in_ready in commit", 32'(in_ready), 32'd0);
    tick();
    chk("done one cycle", 32'(cfg_done), 32'd0);
    chk("idle after commit", 32'(cfg_busy), 32'd0);
    eval(4'd15, 1'b1, "reload x=15");
    eval(4'd3, 1'b0, "reload x=3");

    // Restart mid-load; evaluation during SHIFT still uses 16'h8000.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    eval(4'd15, 1'b1, "shift uses old table");
    send_bits(dffff, 0, 6, 1'b0);
    cfg_start     = 1'b1;
    cfg_bit_valid = 1'b1;
    cfg_bit       = d0001[0];
    tick();
    cfg_start = 1'b0;
    chk("restart no done", 32'(cfg_done), 32'd0);
    send_bits(d0001, 1, 15, 1'b1);
    tick();
    eval(4'd0, 1'b1, "restart x=0");
    eval(4'd15, 1'b0, "restart x=15");
    eval(4'd1, 1'b0, "restart x=1");

    // Reset mid-load.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    send_bits(dffff, 0, 9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid busy", 32'(cfg_busy), 32'd0);
    chk("rst mid done", 32'(cfg_done), 32'd0);
    tick();
    chk("rst mid done later", 32'(cfg_done), 32'd0);
    eval(4'd2, 1'b1, "rst mid x=2");
    eval(4'd0, 1'b0, "rst mid x=0");

    // Multi-channel instance.
    m_eval(3'd0, 2'b11, "m init x=0");
    m_eval(3'd1, 2'b00, "m init x=1");
    m_cfg_start = 1'b1;
    tick();
    m_cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_cfg_bit_valid = 1'b1;
      m_cfg_bit       = d0ff0[i];
      tick();
      chk($sformatf("m cfg_done bit %0d", i), 32'(m_cfg_done), (i == 15) ? 32'd1 : 32'd0);
    end
    m_cfg_bit_valid = 1'b0;
    chk("m in_ready commit", 32'(m_in_ready), 32'd0);
    tick();
    m_eval(3'd5, 2'b01, "m x=5");
    m_eval(3'd2, 2'b10, "m x=2");
    chk("m busy idle", 32'(m_cfg_busy), 32'd0);
    chk("m out_valid", 32'(m_out_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_lut_eval.md
TT_LUT_EVAL -- requirements
Module: tt_lut_eval

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of logic inputs; the truth table depth is 2**N_IN entries; legal range is 2..6.
REQ-002 SHALL have parameter N_CH, default 1: number of independent output channels, each with its own truth table; legal range is 1..8.
REQ-003 SHALL have parameter TT_INIT, width 2**N_IN, default 16'hBC16: reset truth table, loaded into every channel.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port cfg_start, input, 1 bit: begins or restarts a serial table load.
REQ-007 SHALL have port cfg_bit_valid, input, 1 bit: cfg_bit is valid this cycle.
REQ-008 SHALL have port cfg_bit, input, 1 bit: serial truth-table data.
REQ-009 SHALL have port cfg_busy, output, 1 bit: high while in the SHIFT or COMMIT state.
REQ-010 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when the new tables become active.
REQ-011 SHALL have port in_valid, input, 1 bit: input vector offered.
REQ-012 SHALL have port in_ready, output, 1 bit: block accepts the input vector.
REQ-013 SHALL have port in_x, input, N_IN bits: input vector; in_x[0] is the LSB of the table index.
REQ-014 SHALL have port out_valid, output, 1 bit: out_y holds a result.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-016 SHALL have port out_y, output, N_CH bits: bit c is table[c][index].

Function
REQ-017 The config FSM SHALL have the states IDLE, SHIFT and COMMIT.
- IDLE -> SHIFT on cfg_start.
- SHIFT -> COMMIT on the cycle that accepts bit number N_CH*2**N_IN-1.
- COMMIT -> IDLE after exactly one cycle.
REQ-018 In SHIFT, each cycle with cfg_bit_valid=1 SHALL write cfg_bit into shadow[k] and increment the bit counter k, which starts at 0; bit k maps to channel k/2**N_IN, entry k%2**N_IN.
REQ-019 cfg_start asserted in SHIFT SHALL reset k to 0 and stay in SHIFT; when cfg_start and cfg_bit_valid are both asserted, that bit SHALL be stored as bit 0.
REQ-020 cfg_bit_valid in IDLE or COMMIT SHALL be ignored.
REQ-021 In COMMIT, the shadow SHALL be copied to the active tables in one cycle, and cfg_done SHALL be 1 during that same cycle.
REQ-022 The active tables SHALL never be partially updated.
REQ-023 Evaluation SHALL use the active tables only.
REQ-024 in_ready SHALL equal (!out_valid || out_ready) && (state != COMMIT).
REQ-025 An accepted input (in_valid && in_ready) SHALL load out_y = active[c][in_x] for every channel c and set out_valid on the next edge; latency is 1 cycle.
REQ-026 An accepted input on the cycle that follows COMMIT SHALL use the new tables.
REQ-027 While out_valid=1 and out_ready=0, out_y and out_valid SHALL hold stable.
REQ-028 out_valid SHALL clear after a handshake if no new input is accepted in that cycle.
REQ-029 With out_ready held high, the block SHALL sustain one result per cycle; the only bubble is the single COMMIT cycle.
REQ-030 Evaluation SHALL continue normally throughout SHIFT, using the old tables.

Reset
REQ-031 On rst, every channel's active table SHALL load TT_INIT, the shadow SHALL clear to 0, k SHALL be 0, and the state SHALL be IDLE.
REQ-032 On rst, the outputs SHALL be out_valid=0, out_y=0, cfg_busy=0 and cfg_done=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-033 rst during SHIFT SHALL abort the load, with no commit, and restore TT_INIT.
REQ-034 rst SHALL override all other inputs in the same cycle.

Structure
REQ-035 The state enum, the TT_DEPTH = 2**N_IN derivation and the CFG_BITS = N_CH*TT_DEPTH derivation SHALL live in the shared package tt_pkg.
REQ-036 There SHALL be one sub-module, tt_cfg_loader, containing the FSM, counter and shadow register and exporting the shadow and the commit pulse.
REQ-037 The lookup and the output register SHALL stay in the top level.

Verification
REQ-038 Reset lookup: after reset, with defaults, sweep in_x from 0 to 15 with out_ready=1 -> out_y = 0,1,1,0, 1,0,0,0, 0,0,1,1, 1,1,0,1, each one cycle after its input.
REQ-039 Backpressure: hold out_ready=0 after in_x=1 -> out_y stays 1 and in_ready=0; release out_ready -> the next input is accepted in that same cycle.
REQ-040 Reload: cfg_start, then 16 bits of 16'h8000 shifted LSB first -> cfg_done pulses on the cycle after the last bit; then in_x=15 gives 1 and in_x=3 gives 0.
REQ-041 Restart mid-load: send 7 bits, assert cfg_start, then send 16 bits of 16'h0001 -> the active table becomes 16'h0001; no cfg_done before the 16th bit.
REQ-042 Reset mid-load: assert rst after 10 bits -> no cfg_done; the table returns to 16'hBC16 and in_x=2 gives 1.
REQ-043 Multi-channel: with N_CH=2 and N_IN=3, load 16 bits 16'h0FF0 -> channel 0 table 8'hF0, channel 1 table 8'h0F; in_x=5 gives out_y=2'b01.
